gradient_orientation: RTL and testbench

GRADIENT_ORIENTATION -- requirements
Module: gradient_orientation

---
 rtl/sift_pkg.sv | 38 +++
 rtl/orient_bin.sv | 31 +++
 rtl/gradient_orientation.sv | 158 +++++++++++++++
 tb/tb_gradient_orientation.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_pkg.sv
// Shared types for the gradient orientation block: FSM states,
// histogram size and the octant encoding of gradient direction.
package sift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HIST
  } state_t;

  localparam int NUM_BINS = 8;

  localparam logic [2:0] OCT_PX_SHALLOW = 3'd0;
  localparam logic [2:0] OCT_PX_STEEP   = 3'd1;
  localparam logic [2:0] OCT_NX_STEEP   = 3'd2;
  localparam logic [2:0] OCT_NX_SHALLOW = 3'd3;
  localparam logic [2:0] OCT_NN_SHALLOW = 3'd4;
  localparam logic [2:0] OCT_NN_STEEP   = 3'd5;
  localparam logic [2:0] OCT_NY_STEEP   = 3'd6;
  localparam logic [2:0] OCT_NY_SHALLOW = 3'd7;

  function automatic logic [2:0] octant(
    input logic sx,
    input logic sy,
    input logic steep
  );
    logic [2:0] o;
    case ({sx, sy})
      2'b00:   o = steep ? OCT_PX_STEEP : OCT_PX_SHALLOW;
      2'b10:   o = steep ? OCT_NX_STEEP : OCT_NX_SHALLOW;
      2'b11:   o = steep ? OCT_NN_STEEP : OCT_NN_SHALLOW;
      default: o = steep ? OCT_NY_STEEP : OCT_NY_SHALLOW;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/orient_bin.sv
// Combinational L1 magnitude (saturating) and octant bin of one
// signed gradient pair.
module orient_bin
  import sift_pkg::*;
#(
  parameter int BIT_DEPTH = 8
) (
  input  logic signed [BIT_DEPTH-1:0] gx,
  input  logic signed [BIT_DEPTH-1:0] gy,
  output logic        [BIT_DEPTH-1:0] mag,
  output logic        [2:0]           bin
);

  logic signed [BIT_DEPTH:0] gx_w;
  logic signed [BIT_DEPTH:0] gy_w;
  logic        [BIT_DEPTH:0] ax;
  logic        [BIT_DEPTH:0] ay;
  logic        [BIT_DEPTH:0] sum;

  // one extra bit so the most negative input has a representable abs
  always_comb begin
    gx_w = {gx[BIT_DEPTH-1], gx};
    gy_w = {gy[BIT_DEPTH-1], gy};
    ax   = gx_w[BIT_DEPTH] ? $unsigned(-gx_w) : $unsigned(gx_w);
    ay   = gy_w[BIT_DEPTH] ? $unsigned(-gy_w) : $unsigned(gy_w);
    sum  = ax + ay;
    mag  = sum[BIT_DEPTH] ? '1 : sum[BIT_DEPTH-1:0];
    bin  = octant(gx[BIT_DEPTH-1], gy[BIT_DEPTH-1], ay > ax);
  end

endmodule

// File: rtl/gradient_orientation.sv
// Streams a gradient image from BRAM, writes magnitude/bin per pixel.
// ORIENT_HIST_EN adds a per-bin magnitude histogram dumped after each pass.
module gradient_orientation
  import sift_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  parameter int BIT_DEPTH = 8,
  localparam int N  = WIDTH * HEIGHT,
  localparam int AW = $clog2(N),
  localparam int HW = BIT_DEPTH + AW
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        start_in,
  output logic [AW-1:0]               read_addr,
  output logic                        read_valid,
  input  logic signed [BIT_DEPTH-1:0] gx_in,
  input  logic signed [BIT_DEPTH-1:0] gy_in,
  output logic [AW-1:0]               write_addr,
  output logic                        write_valid,
  output logic [BIT_DEPTH-1:0]        mag_out,
  output logic [2:0]                  bin_out,
  output logic                        hist_valid,
  output logic [2:0]                  hist_idx,
  output logic [HW-1:0]               hist_value,
  output logic                        busy,
  output logic                        done
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t               state;
  logic [1:0]           vld_d;
  logic [AW-1:0]        addr_d1;
  logic [AW-1:0]        addr_d2;
  logic [BIT_DEPTH-1:0] mag_c;
  logic [2:0]           bin_c;
  logic                 last_wr;

  orient_bin #(
    .BIT_DEPTH(BIT_DEPTH)
  ) u_bin (
    .gx (gx_in),
    .gy (gy_in),
    .mag(mag_c),
    .bin(bin_c)
  );

  assign last_wr = write_valid && (write_addr == LAST);

`ifdef ORIENT_HIST_EN
  logic [HW-1:0] acc [NUM_BINS];
  logic [3:0]    hcnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_BINS; i++) acc[i] <= '0;
    end else if (state == IDLE && start_in) begin
      for (int i = 0; i < NUM_BINS; i++) acc[i] <= '0;
    end else if (write_valid) begin
      acc[bin_out] <= acc[bin_out] + HW'(mag_out);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcnt       <= '0;
      hist_valid <= 1'b0;
      hist_idx   <= '0;
      hist_value <= '0;
    end else if (state == HIST && !hcnt[3]) begin
      hcnt       <= hcnt + 4'd1;
      hist_valid <= 1'b1;
      hist_idx   <= hcnt[2:0];
      hist_value <= acc[hcnt[2:0]];
    end else begin
      hcnt       <= (state == HIST) ? hcnt : 4'd0;
      hist_valid <= 1'b0;
      hist_idx   <= '0;
      hist_value <= '0;
    end
  end
`else
  assign hist_valid = 1'b0;
  assign hist_idx   = '0;
  assign hist_value = '0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      read_addr   <= '0;
      read_valid  <= 1'b0;
      vld_d       <= '0;
      addr_d1     <= '0;
      addr_d2     <= '0;
      write_addr  <= '0;
      write_valid <= 1'b0;
      mag_out     <= '0;
      bin_out     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      vld_d       <= {vld_d[0], read_valid};
      addr_d1     <= read_addr;
      addr_d2     <= addr_d1;
      write_valid <= vld_d[1];
      if (vld_d[1]) begin
        write_addr <= addr_d2;
        mag_out    <= mag_c;
        bin_out    <= bin_c;
      end
      case (state)
        IDLE: begin
          if (start_in) begin
            state      <= RUN;
            busy       <= 1'b1;
            read_valid <= 1'b1;
            read_addr  <= '0;
          end
        end
        RUN: begin
          if (read_addr == LAST) begin
            read_valid <= 1'b0;
            read_addr  <= '0;
            state      <= DRAIN;
          end else begin
            read_addr <= read_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (last_wr) begin
`ifdef ORIENT_HIST_EN
            state <= HIST;
`else
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end
        end
`ifdef ORIENT_HIST_EN
        HIST: begin
          if (hcnt[3]) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gradient_orientation.sv
// Scoreboard bench for gradient_orientation with a 2-cycle BRAM model.
// Define ORIENT_HIST_EN for both RTL and bench to cover the histogram.
module tb_gradient_orientation;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int BD = 8;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);
  localparam int HW = BD + AW;

  typedef struct {
    int addr;
    int mag;
    int bin;
    int cyc;
  } rec_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [AW-1:0]        read_addr;
  logic                 read_valid;
  logic signed [BD-1:0] gx_in = '0;
  logic signed [BD-1:0] gy_in = '0;
  logic [AW-1:0]        write_addr;
  logic                 write_valid;
  logic [BD-1:0]        mag_out;
  logic [2:0]           bin_out;
  logic                 hist_valid;
  logic [2:0]           hist_idx;
  logic [HW-1:0]        hist_value;
  logic                 busy;
  logic                 done;

  logic signed [BD-1:0] gx_mem [N];
  logic signed [BD-1:0] gy_mem [N];
  logic signed [BD-1:0] gx_p = '0;
  logic signed [BD-1:0] gy_p = '0;

  rec_t exp_q [$];
  rec_t obs_q [$];
  int   hidx_q [$];
  int   hval_q [$];
  int   hcyc_q [$];
  int   cyc = 0;
  int   wr_count = 0;
  int   done_count = 0;
  int   done_cyc = 0;
  int   total = 0;
  int   bad = 0;

  gradient_orientation #(
    .WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD)
  ) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .start_in   (start),
    .read_addr  (read_addr),
    .read_valid (read_valid),
    .gx_in      (gx_in),
    .gy_in      (gy_in),
    .write_addr (write_addr),
    .write_valid(write_valid),
    .mag_out    (mag_out),
    .bin_out    (bin_out),
    .hist_valid (hist_valid),
    .hist_idx   (hist_idx),
    .hist_value (hist_value),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    gx_p  <= gx_mem[read_addr];
    gy_p  <= gy_mem[read_addr];
    gx_in <= gx_p;
    gy_in <= gy_p;
  end

  function automatic int model_mag(int gx, int gy);
    int m;
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return m > 255 ? 255 : m;
  endfunction

  function automatic int model_bin(int gx, int gy);
    int ax, ay;
    ax = gx < 0 ? -gx : gx;
    ay = gy < 0 ? -gy : gy;
    if (gx >= 0 && gy >= 0) return (ay > ax) ? 1 : 0;
    if (gx < 0 && gy >= 0)  return (ay > ax) ? 2 : 3;
    if (gx < 0 && gy < 0)   return (ay > ax) ? 5 : 4;
    return (ay > ax) ? 6 : 7;
  endfunction

  always @(negedge clk) begin
    rec_t r;
    if (read_valid) begin
      r.addr = int'(read_addr);
      r.mag  = model_mag(int'(gx_mem[read_addr]), int'(gy_mem[read_addr]));
      r.bin  = model_bin(int'(gx_mem[read_addr]), int'(gy_mem[read_addr]));
      r.cyc  = cyc;
      exp_q.push_back(r);
    end
    if (write_valid) begin
      r.addr = int'(write_addr);
      r.mag  = int'(mag_out);
      r.bin  = int'(bin_out);
      r.cyc  = cyc;
      obs_q.push_back(r);
      wr_count++;
    end
    if (hist_valid) begin
      hidx_q.push_back(int'(hist_idx));
      hval_q.push_back(int'(hist_value));
      hcyc_q.push_back(cyc);
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    hidx_q.delete();
    hval_q.delete();
    hcyc_q.delete();
  endtask

  task automatic do_pass(output bit ok);
    int d0;
    d0 = done_count;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (done_count != d0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({read_valid, write_valid, done, busy, hist_valid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=00000",
               {read_valid, write_valid, done, busy, hist_valid});
    end
    total++;
    if ({read_addr, write_addr, mag_out, bin_out} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h/%h want=0",
               read_addr, write_addr, mag_out, bin_out);
    end
    total++;
    if ({hist_idx, hist_value} !== '0) begin
      bad++;
      $display("FAIL reset_hist got=%h/%h want=0", hist_idx, hist_value);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_octants();
    bit   ok;
    rec_t e, o;
    int   lit_mag [6] = '{5, 5, 5, 5, 255, 0};
    int   lit_bin [6] = '{0, 3, 6, 1, 4, 0};
    gx_mem[0] = 8'sd5;    gy_mem[0] = 8'sd0;
    gx_mem[1] = -8'sd5;   gy_mem[1] = 8'sd0;
    gx_mem[2] = 8'sd0;    gy_mem[2] = -8'sd5;
    gx_mem[3] = 8'sd0;    gy_mem[3] = 8'sd5;
    gx_mem[4] = -8'sd128; gy_mem[4] = -8'sd128;
    gx_mem[5] = 8'sd0;    gy_mem[5] = 8'sd0;
    gx_mem[6] = -8'sd128; gy_mem[6] = 8'sd127;
    gx_mem[7] = -8'sd128; gy_mem[7] = -8'sd1;
    gx_mem[8] = 8'sd3;    gy_mem[8] = -8'sd9;
    gx_mem[9] = -8'sd2;   gy_mem[9] = -8'sd7;
    gx_mem[10] = 8'sd4;   gy_mem[10] = 8'sd4;
    gx_mem[11] = -8'sd6;  gy_mem[11] = 8'sd6;
    for (int i = 12; i < N; i++) begin
      gx_mem[i] = $signed(8'($urandom));
      gy_mem[i] = $signed(8'($urandom));
    end
    clear_queues();
    do_pass(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL octant_done got=timeout want=done");
    end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].mag != lit_mag[i] || obs_q[i].bin != lit_bin[i]) begin
        bad++;
        $display("FAIL octant_lit%0d got=mag%0d/bin%0d want=mag%0d/bin%0d",
                 i, obs_q[i].mag, obs_q[i].bin, lit_mag[i], lit_bin[i]);
      end
    end
    total++;
    if (obs_q.size() != N) begin
      bad++;
      $display("FAIL octant_count got=%0d want=%0d", obs_q.size(), N);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o.addr != e.addr || o.mag != e.mag || o.bin != e.bin
          || o.cyc - e.cyc != 3) begin
        bad++;
        $display("FAIL octant_sb got=a%0d m%0d b%0d lat%0d want=a%0d m%0d b%0d lat3",
                 o.addr, o.mag, o.bin, o.cyc - e.cyc, e.addr, e.mag, e.bin);
      end
    end
  endtask

  task automatic test_pass_timing();
    bit ok;
    int last;
    for (int i = 0; i < N; i++) begin
      gx_mem[i] = $signed(8'($urandom));
      gy_mem[i] = $signed(8'($urandom));
    end
    clear_queues();
    do_pass(ok);
    total++;
    if (!ok || obs_q.size() != N || exp_q.size() != N) begin
      bad++;
      $display("FAIL pass_count got=ok%0d w%0d r%0d want=ok1 w%0d r%0d",
               ok, obs_q.size(), exp_q.size(), N, N);
      return;
    end
    total++;
    if (obs_q[0].cyc - exp_q[0].cyc != 3) begin
      bad++;
      $display("FAIL pass_first_lat got=%0d want=3", obs_q[0].cyc - exp_q[0].cyc);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (obs_q[i].addr != i || obs_q[i].cyc != obs_q[0].cyc + i) begin
        bad++;
        $display("FAIL pass_seq%0d got=a%0d c%0d want=a%0d c%0d",
                 i, obs_q[i].addr, obs_q[i].cyc, i, obs_q[0].cyc + i);
      end
    end
    last = obs_q[N-1].cyc;
`ifdef ORIENT_HIST_EN
    total++;
    if (hcyc_q.size() != 8 || hcyc_q[0] <= last) begin
      bad++;
      $display("FAIL pass_hist_words got=%0d want=8", hcyc_q.size());
    end else begin
      last = hcyc_q[7];
      total++;
      if (hcyc_q[7] - hcyc_q[0] != 7 || hidx_q[7] != 7) begin
        bad++;
        $display("FAIL pass_hist_seq got=span%0d idx%0d want=span7 idx7",
                 hcyc_q[7] - hcyc_q[0], hidx_q[7]);
      end
    end
`endif
    total++;
    if (done_cyc != last + 1) begin
      bad++;
      $display("FAIL pass_done_cyc got=%0d want=%0d", done_cyc, last + 1);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL pass_busy_after got=%b want=0", busy);
    end
  endtask

`ifdef ORIENT_HIST_EN
  task automatic test_hist();
    bit ok;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) begin
        gx_mem[i] = 8'sd3;
        gy_mem[i] = 8'sd1;
      end
      clear_queues();
      do_pass(ok);
      total++;
      if (!ok || hidx_q.size() != 8) begin
        bad++;
        $display("FAIL hist_words%0d got=%0d want=8", p, hidx_q.size());
      end else begin
        for (int i = 0; i < 8; i++) begin
          total++;
          if (hidx_q[i] != i || hval_q[i] != (i == 0 ? 64 : 0)) begin
            bad++;
            $display("FAIL hist%0d_bin%0d got=idx%0d val%0d want=idx%0d val%0d",
                     p, i, hidx_q[i], hval_q[i], i, (i == 0 ? 64 : 0));
          end
        end
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    int w0;
    for (int i = 0; i < N; i++) begin
      gx_mem[i] = $signed(8'($urandom));
      gy_mem[i] = $signed(8'($urandom));
    end
    clear_queues();
    w0 = wr_count;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (60) @(posedge clk);
    total++;
    if (wr_count - w0 != N) begin
      bad++;
      $display("FAIL b2b_writes got=%0d want=%0d", wr_count - w0, N);
    end
    total++;
    if (busy !== 1'b0 || read_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle got=busy%b rv%b want=busy0 rv0", busy, read_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    bit ok;
    int w0;
    clear_queues();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (read_valid && read_addr == AW'(7)) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL rstmid_reach got=timeout want=addr7");
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({read_valid, write_valid, busy, done, read_addr, write_addr,
         mag_out, bin_out} !== '0) begin
      bad++;
      $display("FAIL rstmid_zero got=rv%b wv%b b%b d%b want=0",
               read_valid, write_valid, busy, done);
    end
    w0 = wr_count;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    total++;
    if (wr_count != w0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_quiet got=w%0d busy%b want=w%0d busy0",
               wr_count - w0, busy, 0);
    end
    clear_queues();
    w0 = wr_count;
    do_pass(ok);
    total++;
    if (!ok || wr_count - w0 != N) begin
      bad++;
      $display("FAIL rstmid_fresh got=ok%0d w%0d want=ok1 w%0d", ok, wr_count - w0, N);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      gx_mem[i] = '0;
      gy_mem[i] = '0;
    end
    test_reset();
    test_octants();
    test_pass_timing();
`ifdef ORIENT_HIST_EN
    test_hist();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
